// File: rtl/sram_req_arbiter.sv
// Two-master (inst/data) to one-slave sram-like request arbiter with in-order owner FIFO.
// Optional `ARB_RR_EN replaces data-priority + starvation counter with round-robin.
module sram_req_arbiter #(
    parameter int OT_DEPTH     = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic        i_wr,
    input  logic [1:0]  i_size,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] i_rdata,
    output logic        i_addr_ok,
    output logic        i_data_ok,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    output logic        s_req,
    output logic        s_wr,
    output logic [1:0]  s_size,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    input  logic        s_addr_ok,
    input  logic        s_data_ok,
    output logic        err_unexp
);
    localparam int PW = (OT_DEPTH > 1) ? $clog2(OT_DEPTH) : 1;
    localparam int CW = $clog2(OT_DEPTH) + 1;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    req_t i_fields, d_fields, s_fields;

    logic [OT_DEPTH-1:0] id_fifo;
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       count;
    logic                full, empty, push, pop, head;
    logic                gnt_i, gnt_d;

    assign full  = (count == CW'(OT_DEPTH));
    assign empty = (count == '0);

`ifdef ARB_RR_EN
    // last_gnt: 0 = inst, 1 = data; on contention the other master wins
    logic last_gnt;

    assign gnt_d = d_req & (~i_req | ~last_gnt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last_gnt <= 1'b1;
        else if (push)
            last_gnt <= gnt_d;
    end
`else
    logic [7:0] starve_cnt;
    logic       force_i;

    assign force_i = (starve_cnt == 8'(STARVE_LIMIT));
    assign gnt_d   = d_req & (~i_req | ~force_i);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            starve_cnt <= '0;
        else if (i_addr_ok)
            starve_cnt <= '0;
        else if (i_req & d_req & ~full & gnt_d & ~force_i)
            starve_cnt <= starve_cnt + 8'd1;
    end
`endif

    assign gnt_i = i_req & ~gnt_d;

    assign i_fields = '{wr: i_wr, size: i_size, addr: i_addr, wdata: i_wdata};
    assign d_fields = '{wr: d_wr, size: d_size, addr: d_addr, wdata: d_wdata};
    assign s_fields = gnt_d ? d_fields : i_fields;

    assign s_req   = (i_req | d_req) & ~full;
    assign s_wr    = s_fields.wr;
    assign s_size  = s_fields.size;
    assign s_addr  = s_fields.addr;
    assign s_wdata = s_fields.wdata;

    assign i_addr_ok = s_addr_ok & s_req & gnt_i;
    assign d_addr_ok = s_addr_ok & s_req & gnt_d;

    assign push = i_addr_ok | d_addr_ok;
    assign pop  = s_data_ok & ~empty;
    assign head = id_fifo[rd_ptr];

    assign i_data_ok = pop & ~head;
    assign d_data_ok = pop & head;
    assign i_rdata   = s_rdata;
    assign d_rdata   = s_rdata;

    // Pointers wrap naturally since OT_DEPTH is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_fifo <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            if (push) begin
                id_fifo[wr_ptr] <= gnt_d;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_unexp <= 1'b0;
        else if (s_data_ok & empty)
            err_unexp <= 1'b1;
    end
endmodule
